rtc_time_loader: RTL and testbench
==================================

# rtc_time_loader

Command initiator for the `rtc_clock` command bus. It accepts a complete target time (hours/minutes/seconds/milliseconds) through a valid/ready request port and emits the command sequence that loads it into the clock: stop, set hours, set minutes, set seconds, set milliseconds, and optionally start. It also issues a single clear command on request. It sits between a host or controller and the `rtc_clock` `cmd_*_i` inputs.

## Interface
- `CMD_GAP`, 15, idle cycles inserted after every issued command (0 allowed: back-to-back commands).
- `clk_i`  in  1  single clock.
- `srst_i`  in  1  synchronous, active-high reset.
- `load_valid_i`  in  1  load request valid.
- `load_ready_o`  out  1  block idle and able to accept a load.
- `load_start_i`  in  1  sampled with load: 1 means issue START after the set commands.
- `load_hours_i`  in  5  target hours, 0..23.
- `load_minutes_i`  in  6  target minutes, 0..59.
- `load_seconds_i`  in  6  target seconds, 0..59.
- `load_ms_i`  in  10  target milliseconds, 0..999.
- `clear_i`  in  1  one-cycle request to issue CLEAR.
- `cmd_type_o`  out  3  command code to `rtc_clock`.
- `cmd_data_o`  out  10  command operand.
- `cmd_valid_o`  out  1  command strobe, 1 cycle per command.
- `done_o`  out  1  1-cycle pulse when a sequence completes.
- `err_o`  out  1  1-cycle pulse when a load is rejected for range.

## Operation
- Command codes: 000 CLEAR (to 00:00:00.000), 001 STOP, 010 START, 111 SET_H, 110 SET_M, 101 SET_S, 100 SET_MS. 011 is never issued.
- `cmd_data_o` carries the field value zero-extended to 10 bits for SET_*; it is 0 for CLEAR, STOP and START.
- When `cmd_valid_o`=0, `cmd_type_o` and `cmd_data_o` are 0.
- FSM states:
  - IDLE: `load_ready_o`=1 only when `clear_i`=0.
  - CMD: drives one command for one cycle.
  - GAP: counts `CMD_GAP` cycles; skipped when `CMD_GAP`=0.
  - Transitions: IDLE→CMD on an accept; CMD→GAP→next CMD, or →IDLE after the last command's gap.
- Load accept is `load_valid_i & load_ready_o`. All fields and `load_start_i` are registered on accept; input changes afterwards have no effect.
- Load sequence: STOP, SET_H, SET_M, SET_S, SET_MS, then START if the registered start flag is 1.
- Clear: `clear_i` in IDLE issues a single CLEAR command. `clear_i` outside IDLE is ignored.
- Simultaneous `clear_i` and `load_valid_i` in IDLE: clear wins and the load is not accepted. Because `load_ready_o` is 0, the requester holds `load_valid_i`.
- Range check on accept: hours>23, minutes>59, seconds>59 or ms>999 means no commands are issued and `err_o` pulses the next cycle. The block stays in IDLE and `load_ready_o` returns to 1 that same next cycle.
- `done_o` pulses in the cycle `load_ready_o` returns high after a load or clear sequence. It does not pulse for a rejected load.
- Gap counter is sized `$clog2(CMD_GAP+1)` bits, minimum 1.

## Timing
- Reset values: all outputs are 0 except `load_ready_o`=1 in the first cycle after reset (state IDLE, `clear_i`=0). Counter and registered fields are cleared.
- Accept at cycle 0. Command k (0-based) is valid at cycle 1+k·(CMD_GAP+1).
- Ready returns, with `done_o`, at cycle 1+N·(CMD_GAP+1), where N is the number of commands: 6 with start, 5 without, 1 for clear.
- `CMD_GAP`=15: STOP@1, SET_H@17, SET_M@33, SET_S@49, SET_MS@65, START@81, ready@97. Without start, ready@81. For clear, CLEAR@1, ready@17.
- `CMD_GAP`=0: commands on consecutive cycles 1..6, ready@7.
- `srst_i` mid-sequence: at the next edge the FSM is in IDLE and all outputs take their reset values. No partial command is completed, and no `done_o` pulse is produced.
- There is no backpressure from `rtc_clock`; each command is presented for exactly one cycle.

## Test plan
- Reset, then load 23:59:59.002 with start=1, `CMD_GAP`=15 → STOP@1, 111/23@17, 110/59@33, 101/59@49, 100/2@65, 010/0@81, `done_o` and ready@97.
- Load 05:07:09.999 with start=0 → five commands ending with 100/999@65; no START; ready and `done_o`@81.
- Load with minutes=60 → no `cmd_valid_o`, `err_o`=1@1, `load_ready_o`=1@1, no `done_o`.
- `clear_i` and `load_valid_i` both high in IDLE → 000/0@1, load not accepted. The held load is accepted @17 and its STOP is issued @18.
- `srst_i` at cycle 40 of a load → `cmd_valid_o`=0 from cycle 41, `load_ready_o`=1 @41, no `done_o`. A new load then runs a full sequence.
- `CMD_GAP`=0, load 12:00:00.000 with start=1 → six back-to-back commands on cycles 1..6, ready@7.

Source files
------------

// File: rtl/rtc_time_loader.sv
// rtc_time_loader: turns one complete target time into the rtc_clock command
// sequence STOP, SET_H, SET_M, SET_S, SET_MS and an optional START. It can
// also issue a single CLEAR. Every command is a one-cycle strobe followed by
// CMD_GAP idle cycles.
module rtc_time_loader #(
    parameter int CMD_GAP = 15
) (
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic       load_valid_i,
    output logic       load_ready_o,
    input  logic       load_start_i,
    input  logic [4:0] load_hours_i,
    input  logic [5:0] load_minutes_i,
    input  logic [5:0] load_seconds_i,
    input  logic [9:0] load_ms_i,
    input  logic       clear_i,
    output logic [2:0] cmd_type_o,
    output logic [9:0] cmd_data_o,
    output logic       cmd_valid_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int CNT_W = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
    // The counter is loaded on the cycle after the command, so the GAP
    // state lasts CMD_GAP cycles when it starts from CMD_GAP-1.
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);

    localparam logic [2:0] CMD_CLEAR  = 3'b000;
    localparam logic [2:0] CMD_STOP   = 3'b001;
    localparam logic [2:0] CMD_START  = 3'b010;
    localparam logic [2:0] CMD_SET_H  = 3'b111;
    localparam logic [2:0] CMD_SET_M  = 3'b110;
    localparam logic [2:0] CMD_SET_S  = 3'b101;
    localparam logic [2:0] CMD_SET_MS = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_GAP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       step_q;      // index of the next command to issue
    logic             last_q;      // command just issued ends the sequence
    logic             start_q;
    logic [4:0]       hours_q;
    logic [5:0]       minutes_q;
    logic [5:0]       seconds_q;
    logic [9:0]       ms_q;
    logic [2:0]       cmd_type_q;
    logic [9:0]       cmd_data_q;
    logic             cmd_valid_q;
    logic             done_q;
    logic             err_q;

    logic [2:0]       next_type_d;
    logic [9:0]       next_data_d;
    logic             next_last_d;
    logic             range_ok;

    assign range_ok = (load_hours_i <= 5'd23) && (load_minutes_i <= 6'd59) &&
                      (load_seconds_i <= 6'd59) && (load_ms_i <= 10'd999);

    // Ready is withheld while a clear request is present so clear wins a tie.
    assign load_ready_o = (state_q == ST_IDLE) && !clear_i;

    assign cmd_type_o  = cmd_type_q;
    assign cmd_data_o  = cmd_data_q;
    assign cmd_valid_o = cmd_valid_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    // Decode the command that follows STOP from the step index and latched fields.
    always_comb begin
        next_type_d = CMD_START;
        next_data_d = '0;
        next_last_d = 1'b1;
        case (step_q)
            3'd1: begin
                next_type_d = CMD_SET_H;
                next_data_d = {5'd0, hours_q};
                next_last_d = 1'b0;
            end
            3'd2: begin
                next_type_d = CMD_SET_M;
                next_data_d = {4'd0, minutes_q};
                next_last_d = 1'b0;
            end
            3'd3: begin
                next_type_d = CMD_SET_S;
                next_data_d = {4'd0, seconds_q};
                next_last_d = 1'b0;
            end
            3'd4: begin
                next_type_d = CMD_SET_MS;
                next_data_d = ms_q;
                next_last_d = !start_q;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered command, done and error outputs.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            step_q      <= '0;
            last_q      <= 1'b0;
            start_q     <= 1'b0;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            ms_q        <= '0;
            cmd_type_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clear_i) begin
                        state_q     <= ST_CMD;
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= CMD_CLEAR;
                        last_q      <= 1'b1;
                    end else if (load_valid_i) begin
                        if (range_ok) begin
                            hours_q     <= load_hours_i;
                            minutes_q   <= load_minutes_i;
                            seconds_q   <= load_seconds_i;
                            ms_q        <= load_ms_i;
                            start_q     <= load_start_i;
                            step_q      <= 3'd1;
                            last_q      <= 1'b0;
                            state_q     <= ST_CMD;
                            cmd_valid_q <= 1'b1;
                            cmd_type_q  <= CMD_STOP;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_CMD: begin
                    if (CMD_GAP != 0) begin
                        state_q <= ST_GAP;
                        cnt_q   <= CNT_RELOAD;
                    end else if (last_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= next_type_d;
                        cmd_data_q  <= next_data_d;
                        last_q      <= next_last_d;
                        step_q      <= step_q + 3'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        if (last_q) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_CMD;
                            cmd_valid_q <= 1'b1;
                            cmd_type_q  <= next_type_d;
                            cmd_data_q  <= next_data_d;
                            last_q      <= next_last_d;
                            step_q      <= step_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_time_loader.sv
// Scoreboard bench for rtc_time_loader: CMD_GAP=15 instance (a) and a
// CMD_GAP=0 instance (b). Expected events are queued when stimulus is issued
// and a monitor per instance pops and compares every observed output event.
module tb_rtc_time_loader;

    typedef struct {
        logic [2:0] fl;   // {cmd_valid, done, err}
        int         cyc;
        logic [2:0] ty;
        logic [9:0] da;
    } ev_t;

    logic clk = 1'b0;
    logic srst = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   mon_en = 1'b0;
    ev_t  qa[$];
    ev_t  qb[$];

    // instance a
    logic       a_valid = 0, a_start = 0, a_clear = 0;
    logic [4:0] a_h = 0;
    logic [5:0] a_m = 0, a_s = 0;
    logic [9:0] a_ms = 0;
    logic       a_ready, a_cvalid, a_done, a_err;
    logic [2:0] a_type;
    logic [9:0] a_data;
    // instance b
    logic       b_valid = 0, b_start = 0, b_clear = 0;
    logic [4:0] b_h = 0;
    logic [5:0] b_m = 0, b_s = 0;
    logic [9:0] b_ms = 0;
    logic       b_ready, b_cvalid, b_done, b_err;
    logic [2:0] b_type;
    logic [9:0] b_data;

    rtc_time_loader #(.CMD_GAP(15)) dut_a (
        .clk_i(clk), .srst_i(srst), .load_valid_i(a_valid), .load_ready_o(a_ready),
        .load_start_i(a_start), .load_hours_i(a_h), .load_minutes_i(a_m),
        .load_seconds_i(a_s), .load_ms_i(a_ms), .clear_i(a_clear),
        .cmd_type_o(a_type), .cmd_data_o(a_data), .cmd_valid_o(a_cvalid),
        .done_o(a_done), .err_o(a_err)
    );

    rtc_time_loader #(.CMD_GAP(0)) dut_b (
        .clk_i(clk), .srst_i(srst), .load_valid_i(b_valid), .load_ready_o(b_ready),
        .load_start_i(b_start), .load_hours_i(b_h), .load_minutes_i(b_m),
        .load_seconds_i(b_s), .load_ms_i(b_ms), .clear_i(b_clear),
        .cmd_type_o(b_type), .cmd_data_o(b_data), .cmd_valid_o(b_cvalid),
        .done_o(b_done), .err_o(b_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic exp_ev(input bit b, input logic [2:0] fl, input int cy,
                          input logic [2:0] ty, input logic [9:0] da);
        ev_t e;
        e.fl = fl; e.cyc = cy; e.ty = ty; e.da = da;
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    // Hand-ordered load sequence: STOP, SET_H, SET_M, SET_S, SET_MS, [START], done.
    task automatic exp_load(input bit b, input int base, input int gap,
                            input int h, input int m, input int s, input int ms, input bit st);
        int p;
        p = gap + 1;
        exp_ev(b, 3'b100, base + 1,         3'b001, 10'd0);
        exp_ev(b, 3'b100, base + 1 + p,     3'b111, 10'(h));
        exp_ev(b, 3'b100, base + 1 + 2 * p, 3'b110, 10'(m));
        exp_ev(b, 3'b100, base + 1 + 3 * p, 3'b101, 10'(s));
        exp_ev(b, 3'b100, base + 1 + 4 * p, 3'b100, 10'(ms));
        if (st) begin
            exp_ev(b, 3'b100, base + 1 + 5 * p, 3'b010, 10'd0);
            exp_ev(b, 3'b010, base + 1 + 6 * p, 3'b000, 10'd0);
        end else begin
            exp_ev(b, 3'b010, base + 1 + 5 * p, 3'b000, 10'd0);
        end
    endtask

    task automatic wait_cyc(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    // Presents a one-cycle load on instance a; returns the accept cycle.
    task automatic drive_a(input int h, input int m, input int s, input int ms,
                           input bit st, output int base);
        @(negedge clk);
        base = cyc;
        a_h = 5'(h); a_m = 6'(m); a_s = 6'(s); a_ms = 10'(ms); a_start = st;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic mon_one(input string nm, input bit b, input logic cv, input logic dn,
                           input logic er, input logic [2:0] ty, input logic [9:0] da);
        ev_t e;
        logic [2:0] fl;
        bit ok;
        fl = {cv, dn, er};
        if (fl != 3'b000) begin
            total_cnt++;
            if ((b ? qb.size() : qa.size()) == 0) begin
                $display("FAIL %s unexpected event: flags %b type %b data %0d at cycle %0d, expected none",
                         nm, fl, ty, da, cyc);
            end else begin
                e = b ? qb.pop_front() : qa.pop_front();
                ok = (fl == e.fl) && (cyc == e.cyc) && (!cv || (ty == e.ty && da == e.da));
                if (ok) pass_cnt++;
                else $display("FAIL %s event: got flags %b type %b data %0d cycle %0d, expected flags %b type %b data %0d cycle %0d",
                              nm, fl, ty, da, cyc, e.fl, e.ty, e.da, e.cyc);
            end
        end
        if (!cv) begin
            total_cnt++;
            if (ty == 3'b000 && da == 10'd0) pass_cnt++;
            else $display("FAIL %s idle_bus: got type %b data %0d, expected 0/0 at cycle %0d",
                          nm, ty, da, cyc);
        end
    endtask

    // Monitors: compare every presented event against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_one("a", 1'b0, a_cvalid, a_done, a_err, a_type, a_data);
            mon_one("b", 1'b1, b_cvalid, b_done, b_err, b_type, b_data);
        end
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
        #1;
        chk("reset_ready", a_ready, 1);
        chk("reset_cmd_valid", a_cvalid, 0);
        chk("reset_done", a_done, 0);
        chk("reset_err", a_err, 0);
        chk("reset_type_data", {a_type, a_data}, 0);
        chk("reset_ready_b", b_ready, 1);
        mon_en = 1'b1;

        // 23:59:59.002 with start
        qa.push_back('{3'b000, 0, 3'b000, 10'd0}); qa.pop_back();
        @(negedge clk);
        c = cyc + 1;
        exp_load(1'b0, c, 15, 23, 59, 59, 2, 1'b1);
        drive_a(23, 59, 59, 2, 1'b1, c);
        wait_cyc(c + 50);
        chk("busy_ready", a_ready, 0);
        wait_cyc(c + 97);
        chk("ready_after_start_seq", a_ready, 1);

        // 05:07:09.999 without start
        c = cyc + 1;
        exp_load(1'b0, c, 15, 5, 7, 9, 999, 1'b0);
        drive_a(5, 7, 9, 999, 1'b0, c);
        wait_cyc(c + 80);
        chk("ready_before_nostart_done", a_ready, 0);
        wait_cyc(c + 81);
        chk("ready_after_nostart_seq", a_ready, 1);

        // minutes out of range
        c = cyc + 1;
        exp_ev(1'b0, 3'b001, c + 1, 3'b000, 10'd0);
        drive_a(1, 60, 0, 0, 1'b1, c);
        wait_cyc(c + 1);
        chk("ready_after_reject", a_ready, 1);

        // clear and load together: clear wins, held load accepted after
        @(negedge clk);
        c = cyc;
        exp_ev(1'b0, 3'b100, c + 1, 3'b000, 10'd0);
        exp_ev(1'b0, 3'b010, c + 17, 3'b000, 10'd0);
        exp_load(1'b0, c + 17, 15, 1, 2, 3, 4, 1'b0);
        a_h = 5'd1; a_m = 6'd2; a_s = 6'd3; a_ms = 10'd4; a_start = 1'b0;
        a_valid = 1'b1; a_clear = 1'b1;
        #1;
        chk("ready_low_on_clear", a_ready, 0);
        @(posedge clk);
        #1 a_clear = 1'b0;
        wait_cyc(c + 16);
        chk("held_load_waits", a_ready, 0);
        wait_cyc(c + 17);
        chk("ready_after_clear", a_ready, 1);
        @(posedge clk);
        #1 a_valid = 1'b0;
        wait_cyc(c + 98);
        chk("ready_after_held_load", a_ready, 1);

        // reset in the middle of a load
        c = cyc + 1;
        exp_ev(1'b0, 3'b100, c + 1,  3'b001, 10'd0);
        exp_ev(1'b0, 3'b100, c + 17, 3'b111, 10'd8);
        exp_ev(1'b0, 3'b100, c + 33, 3'b110, 10'd30);
        drive_a(8, 30, 45, 500, 1'b1, c);
        wait_cyc(c + 40);
        srst = 1'b1;
        @(posedge clk);
        #1 srst = 1'b0;
        wait_cyc(c + 41);
        chk("srst_cmd_valid", a_cvalid, 0);
        chk("srst_ready", a_ready, 1);
        wait_cyc(c + 60);
        chk("idle_after_srst", a_ready, 1);
        c = cyc + 1;
        exp_load(1'b0, c, 15, 10, 20, 30, 400, 1'b1);
        drive_a(10, 20, 30, 400, 1'b1, c);
        wait_cyc(c + 97);
        chk("ready_after_reload", a_ready, 1);

        // CMD_GAP=0 back-to-back on instance b
        @(negedge clk);
        c = cyc;
        exp_load(1'b1, c, 0, 12, 0, 0, 0, 1'b1);
        b_h = 5'd12; b_m = 6'd0; b_s = 6'd0; b_ms = 10'd0; b_start = 1'b1;
        b_valid = 1'b1;
        @(posedge clk);
        #1 b_valid = 1'b0;
        wait_cyc(c + 6);
        chk("b_ready_busy", b_ready, 0);
        wait_cyc(c + 7);
        chk("b_ready_after", b_ready, 1);

        repeat (20) @(negedge clk);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
